// File: rtl/fp_adder_pipe.sv
// IEEE-754 binary32 adder, round-to-nearest-even, STAGES = 1..3 register stages.
// Define FP_ADDER_SUBNORMAL_EN for gradual underflow; otherwise inputs DAZ, results FTZ.
module fp_adder_pipe #(
  parameter int STAGES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

`ifdef FP_ADDER_SUBNORMAL_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif

  localparam logic [31:0] QNAN = 32'h7fc00000;

  typedef struct packed {
    logic        special;
    logic [31:0] sval;
    logic        sign;
    logic        sub;
    logic        zsign;
    logic [7:0]  exp;
    logic [26:0] ma;
    logic [26:0] mb;
  } al_t;

  typedef struct packed {
    logic        special;
    logic [31:0] sval;
    logic        zero;
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] m;
  } nm_t;

  // {effective exponent, 24-bit mantissa with hidden bit}
  function automatic logic [31:0] unpack_em(input logic [30:0] x);
    logic [7:0]  e;
    logic [23:0] m;
    if (x[30:23] == 8'd0) begin
      e = SUBN ? 8'd1 : 8'd0;
      m = SUBN ? {1'b0, x[22:0]} : 24'd0;
    end else begin
      e = x[30:23];
      m = {1'b1, x[22:0]};
    end
    return {e, m};
  endfunction

  function automatic al_t align(input logic [31:0] x,
                                input logic [31:0] y);
    al_t         r;
    logic        nx, ny, ix, iy, swap;
    logic [31:0] ux, uy, big, sml;
    logic [7:0]  diff;
    logic [51:0] wide;
    nx   = (&x[30:23]) & (|x[22:0]);
    ny   = (&y[30:23]) & (|y[22:0]);
    ix   = (&x[30:23]) & ~(|x[22:0]);
    iy   = (&y[30:23]) & ~(|y[22:0]);
    ux   = unpack_em(x[30:0]);
    uy   = unpack_em(y[30:0]);
    swap = uy > ux;
    big  = swap ? uy : ux;
    sml  = swap ? ux : uy;
    diff = big[31:24] - sml[31:24];
    wide = {sml[23:0], 28'd0} >> diff;
    r       = '0;
    r.sign  = swap ? y[31] : x[31];
    r.sub   = x[31] ^ y[31];
    r.zsign = x[31] & y[31];
    r.exp   = big[31:24];
    r.ma    = {big[23:0], 3'b000};
    if (diff >= 8'd26)
      r.mb = {26'd0, |sml[23:0]};
    else
      r.mb = {wide[51:26], |wide[25:0]};
    if (nx | ny | (ix & iy & (x[31] ^ y[31]))) begin
      r.special = 1'b1;
      r.sval    = QNAN;
    end else if (ix) begin
      r.special = 1'b1;
      r.sval    = {x[31], 8'hff, 23'd0};
    end else if (iy) begin
      r.special = 1'b1;
      r.sval    = {y[31], 8'hff, 23'd0};
    end
    return r;
  endfunction

  function automatic logic [7:0] lzc(input logic [26:0] v);
    logic [7:0] n;
    logic       hit;
    n   = 8'd0;
    hit = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!hit && !v[i]) n = n + 8'd1;
      else hit = 1'b1;
    end
    return n;
  endfunction

  function automatic nm_t normalize(input al_t s);
    nm_t         r;
    logic [27:0] sum;
    logic [7:0]  lz, sh;
    r         = '0;
    r.special = s.special;
    r.sval    = s.sval;
    r.sign    = s.sign;
    sum = s.sub ? {1'b0, s.ma} - {1'b0, s.mb}
                : {1'b0, s.ma} + {1'b0, s.mb};
    lz  = lzc(sum[26:0]);
    // with gradual underflow the shift stops at exponent 1
    sh  = (SUBN && lz >= s.exp) ? s.exp - 8'd1 : lz;
    unique case (1'b1)
      sum == 28'd0: begin
        r.zero = 1'b1;
        r.sign = s.zsign;
      end
      sum[27]: begin
        r.exp = {2'b00, s.exp} + 10'd1;
        r.m   = {sum[27:2], |sum[1:0]};
      end
      default: begin
        if (!SUBN && lz >= s.exp) begin
          r.zero = 1'b1;
        end else begin
          r.exp = {2'b00, s.exp - sh};
          r.m   = sum[26:0] << sh;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] round_pack(input nm_t s);
    logic        up;
    logic [24:0] rm;
    logic [9:0]  e;
    logic [31:0] r;
    up = s.m[2] & (s.m[3] | s.m[1] | s.m[0]);
    rm = {1'b0, s.m[26:3]} + {24'd0, up};
    e  = rm[24] ? s.exp + 10'd1 : s.exp;
    if (s.special)
      r = s.sval;
    else if (s.zero)
      r = {s.sign, 31'd0};
    else if (e >= 10'd255)
      r = {s.sign, 8'hff, 23'd0};
    else if (!rm[24] && !rm[23])
      r = {s.sign, 8'd0, rm[22:0]};
    else
      r = {s.sign, e[7:0], rm[22:0]};
    return r;
  endfunction

  logic [31:0] res_q;
  assign result = res_q;

  generate
    if (STAGES == 1) begin : g_s1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) res_q <= '0;
        else       res_q <= round_pack(normalize(align(a, b)));
      end
    end else if (STAGES == 2) begin : g_s2
      al_t al_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          al_q  <= '0;
          res_q <= '0;
        end else begin
          al_q  <= align(a, b);
          res_q <= round_pack(normalize(al_q));
        end
      end
    end else if (STAGES == 3) begin : g_s3
      al_t al_q;
      nm_t nm_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          al_q  <= '0;
          nm_q  <= '0;
          res_q <= '0;
        end else begin
          al_q  <= align(a, b);
          nm_q  <= normalize(al_q);
          res_q <= round_pack(nm_q);
        end
      end
    end else begin : g_bad
      $error("fp_adder_pipe: STAGES must be 1, 2 or 3");
    end
  endgenerate

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Scoreboard bench for fp_adder_pipe: STAGES 1/2/3 side by side,
// directed vectors plus random pairs against a binary64-based reference.
module tb_fp_adder_pipe;

  localparam logic [31:0] QNAN = 32'h7fc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] r1, r2, r3;
  logic [31:0] rr [3];
  logic        dv = 1'b0;
  logic [2:0]  vh = '0;
  logic [31:0] q [3][$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  fp_adder_pipe #(.STAGES(1)) u1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .result(r1));
  fp_adder_pipe #(.STAGES(2)) u2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .result(r2));
  fp_adder_pipe #(.STAGES(3)) u3 (
    .clk(clk), .reset(reset), .a(a), .b(b), .result(r3));

  assign rr[0] = r1;
  assign rr[1] = r2;
  assign rr[2] = r3;

  function automatic real f2r(input logic [31:0] x);
    real v;
    if (x[30:23] == 8'd0) begin
`ifdef FP_ADDER_SUBNORMAL_EN
      if (x[22:0] == 23'd0) return $bitstoreal({x[31], 63'd0});
      v = $itor(int'(x[22:0])) * 2.0 ** (-149);
      return x[31] ? -v : v;
`else
      return $bitstoreal({x[31], 63'd0});
`endif
    end
    v = $bitstoreal({x[31], 11'(int'(x[30:23]) + 896),
                     x[22:0], 29'd0});
    return v;
  endfunction

  // exact sum in binary64, then one RNE rounding to binary32
  function automatic logic [31:0] model(input logic [31:0] x,
                                        input logic [31:0] y);
    real         d, m;
    logic [63:0] bits;
    logic [52:0] mant;
    logic [24:0] k;
    logic        up;
    int          e;
    int          n;
    if ((&x[30:23] && |x[22:0]) || (&y[30:23] && |y[22:0]))
      return QNAN;
    if (&x[30:23] && &y[30:23])
      return (x[31] == y[31]) ? x : QNAN;
    if (&x[30:23]) return x;
    if (&y[30:23]) return y;
    d    = f2r(x) + f2r(y);
    bits = $realtobits(d);
    if (bits[62:52] == 11'd0) return {bits[63], 31'd0};
    e = int'(bits[62:52]) - 896;
    if (e < 1) begin
`ifdef FP_ADDER_SUBNORMAL_EN
      m = (d < 0.0) ? -d : d;
      n = $rtoi(m * 2.0 ** 149);
      return {bits[63], 31'(n)};
`else
      return {bits[63], 31'd0};
`endif
    end
    mant = {1'b1, bits[51:0]};
    up   = mant[28] & ((|mant[27:0]) | mant[29]);
    k    = {1'b0, mant[52:29]} + {24'd0, up};
    if (k[24]) e = e + 1;
    if (e >= 255) return {bits[63], 8'hff, 23'd0};
    return {bits[63], 8'(e), k[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] e);
    @(negedge clk);
    a  = x;
    b  = y;
    dv = 1'b1;
    for (int k = 0; k < 3; k++) q[k].push_back(e);
  endtask

  function automatic logic [31:0] rnd_pair_b(input logic [31:0] x);
    int eb;
    if ($urandom_range(9) == 0) return $urandom;
    eb = int'(x[30:23]) + int'($urandom_range(8)) - 4;
    if ($urandom_range(3) == 0) eb = int'($urandom_range(254, 1));
    if (eb < 1) eb = 1;
    if (eb > 254) eb = 254;
    return {1'($urandom_range(1)), 8'(eb), 23'($urandom)};
  endfunction

  task automatic send_random(input int count);
    logic [31:0] x, y;
    for (int i = 0; i < count; i++) begin
      x = {1'($urandom_range(1)), 8'($urandom_range(254, 1)),
           23'($urandom)};
      if ($urandom_range(9) == 0) x = $urandom;
      y = rnd_pair_b(x);
      send(x, y, model(x, y));
    end
  endtask

  // monitor: vh[k] marks that stage-(k+1) DUT shows a real sum now
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      vh = {vh[1:0], dv & ~reset};
      #1;
      for (int k = 0; k < 3; k++) begin
        if (vh[k]) begin
          if (q[k].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL s%0d_extra: got %h expected nothing",
                     k + 1, rr[k]);
          end else begin
            e = q[k].pop_front();
            check($sformatf("s%0d_sum", k + 1), rr[k], e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_s1", r1, 32'h0);
    check("reset_s2", r2, 32'h0);
    check("reset_s3", r3, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    send(32'h3f800000, 32'h3f800000, 32'h40000000);
    send(32'h3fc00000, 32'h40100000, 32'h40700000);
    send(32'h3f800000, 32'h33800000, 32'h3f800000);
    send(32'h3f800000, 32'h33800001, 32'h3f800001);
    send(32'h3f800000, 32'hbf800000, 32'h00000000);
    send(32'h7f800000, 32'hff800000, 32'h7fc00000);
    send(32'h7fc00001, 32'h3f800000, 32'h7fc00000);
    send(32'h7f7fffff, 32'h7f7fffff, 32'h7f800000);
    send(32'h80000000, 32'h80000000, 32'h80000000);
    send(32'hff800000, 32'h3f800000, 32'hff800000);
    send(32'h3fffffff, 32'h34000000, 32'h40000000);
`ifdef FP_ADDER_SUBNORMAL_EN
    send(32'h00000001, 32'h00000001, 32'h00000002);
    send(32'h00400000, 32'h00400000, 32'h00800000);
`else
    send(32'h00000001, 32'h00000001, 32'h00000000);
    send(32'h00400000, 32'h00400000, 32'h00000000);
`endif

    send_random(200);

    @(posedge clk);
    #2;
    reset = 1'b1;
    dv    = 1'b0;
    #1;
    check("midreset_s1", r1, 32'h0);
    check("midreset_s2", r2, 32'h0);
    check("midreset_s3", r3, 32'h0);
    for (int k = 0; k < 3; k++) q[k].delete();
    vh = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    send_random(20);

    @(negedge clk);
    dv = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (q[k].size() != 0) begin
        miscompares++;
        $display("FAIL s%0d_drain: got %0d pending expected 0",
                 k + 1, q[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_adder_pipe.md
Name: fp_adder_pipe

Overview:
- IEEE-754 binary32 adder: computes result = a + b, round-to-nearest-even.
- Pipeline depth set by a parameter (1, 2 or 3 register stages).
- Accepts a new operand pair every cycle; no handshake.
- Used as the datapath adder in the adder latency/area sweep experiments.

Parameters:
- STAGES, 1, number of register stages = latency in cycles; legal values 1, 2, 3; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all pipeline state.
- a  input  32  operand A, binary32.
- b  input  32  operand B, binary32.
- result  output  32  binary32 sum, registered.

Behaviour:
- Reset:
  - Asserting reset immediately clears every pipeline register, including result, to 0x00000000.
  - Release is synchronous to clk.
  - Reset mid-operation discards all in-flight sums.
- Timing:
  - a and b are sampled at every rising edge; result = a+b exactly STAGES rising edges after sampling.
  - Throughput is 1 per cycle.
  - The result register is the last stage, so result has no combinational path from a or b.
- Stage partition:
  - Stage 1: unpack, classify, swap so |A| ≥ |B|, align the smaller mantissa with guard/round/sticky bits.
  - Stage 2: add/subtract, leading-zero count, normalize.
  - Stage 3: round, pack.
  - STAGES=1: all three steps combinational before one register.
  - STAGES=2: register after alignment.
  - STAGES=3: register after alignment and after normalization.
- Arithmetic:
  - Mantissa datapath is 24 bits with hidden 1, plus guard, round and sticky.
  - Alignment shifts of ≥ 26 collapse the operand into sticky.
  - Effective subtraction uses the sign of the larger magnitude.
  - Rounding is RNE; mantissa carry-out from rounding increments the exponent.
- Special cases (highest priority first):
  - Either input NaN → 0x7FC00000 (canonical quiet NaN).
  - +Inf + -Inf → 0x7FC00000.
  - Inf with a finite operand → that Inf. Inf + same-sign Inf → that Inf.
  - Exact zero result from opposite-sign operands → +0. (-0)+(-0) → -0.
  - Exponent overflow after rounding → signed Inf (0x7F800000 / 0xFF800000).
- Subnormals (default build):
  - Subnormal inputs are treated as signed zero (DAZ).
  - Results below the minimum normal are flushed to signed zero (FTZ).
- No status flags are produced.

Optional Feature:
- Macro FP_ADDER_SUBNORMAL_EN.
- Defined:
  - Full gradual underflow: subnormal inputs use hidden bit 0 and exponent 1.
  - Tiny results are denormalized before rounding and emitted as subnormals.
  - A subnormal that rounds up to the minimum normal becomes exponent 1.
- Undefined: DAZ/FTZ behaviour as above.
- Latency and stage count are identical in both builds.

Test Plan:
- Basic sums, each checked after exactly STAGES edges for STAGES ∈ {1,2,3}:
  - 0x3F800000 + 0x3F800000 → 0x40000000.
  - 0x3FC00000 + 0x40100000 → 0x40700000.
- Rounding ties and cancellation:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
  - 0x3F800000 + 0x33800001 → 0x3F800001.
  - 0x3F800000 + 0xBF800000 → 0x00000000.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Back-to-back streaming: a new pair every cycle for 20 cycles, random normals vs a golden model → each result appears in order, STAGES cycles later, no bubbles.
- Reset: assert reset asynchronously mid-stream with pipeline full → result reads 0x00000000 before the next edge; after release, the first valid output appears STAGES edges after the first post-reset sample.
- Subnormals: 0x00000001 + 0x00000001:
  - Default build → 0x00000000.
  - FP_ADDER_SUBNORMAL_EN build → 0x00000002.
  - 0x00400000 + 0x00400000 with the macro → 0x00800000.
